// File: rtl/niosii_system_gpio_in.sv
// Avalon-MM input PIO: synchronised and debounced input pins, per-bit
// rise/fall edge selection, write-1-to-clear edge capture and a masked level irq.
module niosii_system_gpio_in #(
   parameter int WIDTH           = 8,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   input  logic [WIDTH-1:0] in_port,
   output logic [31:0]      readdata,
   output logic             irq
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [2:0] ADDR_DATA    = 3'd0;
   localparam logic [2:0] ADDR_RISE_EN = 3'd1;
   localparam logic [2:0] ADDR_MASK    = 3'd2;
   localparam logic [2:0] ADDR_EDGE    = 3'd3;
   localparam logic [2:0] ADDR_FALL_EN = 3'd4;
   localparam logic [2:0] ADDR_RAW     = 3'd5;

   logic [WIDTH-1:0] meta_q, sync_q;
   logic [WIDTH-1:0] stable_q, stable_d;
   logic [CNT_W-1:0] cnt_q [WIDTH];
   logic [CNT_W-1:0] cnt_d [WIDTH];
   logic [WIDTH-1:0] upd, rise, fall, set;
   logic [WIDTH-1:0] rise_en_q, rise_en_d;
   logic [WIDTH-1:0] fall_en_q, fall_en_d;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] edge_q, edge_d;
   logic [WIDTH-1:0] clr;
   logic [WIDTH-1:0] wdata;
   logic [31:0]      readdata_q, readdata_d;
   logic             wr_en;
   logic             unused_wdata;

   assign wr_en        = chipselect & ~write_n;
   assign wdata        = writedata[WIDTH-1:0];
   assign unused_wdata = ^writedata;

   // Per-bit debounce: accept sync only after it has differed for DEBOUNCE_CYCLES clocks
   always_comb begin
      stable_d = stable_q;
      upd      = '0;
      for (int i = 0; i < WIDTH; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync_q[i] == stable_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            stable_d[i] = sync_q[i];
            cnt_d[i]    = '0;
            upd[i]      = 1'b1;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   assign rise = upd & sync_q;
   assign fall = upd & ~sync_q;
   assign set  = (rise & rise_en_q) | (fall & fall_en_q);

   // A new edge wins over a simultaneous write-1-to-clear on the same bit
   assign clr    = (wr_en && address == ADDR_EDGE) ? wdata : '0;
   assign edge_d = set | (edge_q & ~clr);

   assign rise_en_d = (wr_en && address == ADDR_RISE_EN) ? wdata : rise_en_q;
   assign fall_en_d = (wr_en && address == ADDR_FALL_EN) ? wdata : fall_en_q;
   assign mask_d    = (wr_en && address == ADDR_MASK)    ? wdata : mask_q;

   always_comb begin
      readdata_d = '0;
      case (address)
         ADDR_DATA:    readdata_d = 32'(stable_q);
         ADDR_RISE_EN: readdata_d = 32'(rise_en_q);
         ADDR_MASK:    readdata_d = 32'(mask_q);
         ADDR_EDGE:    readdata_d = 32'(edge_q);
         ADDR_FALL_EN: readdata_d = 32'(fall_en_q);
         ADDR_RAW:     readdata_d = 32'(sync_q);
         default:      readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta_q     <= '0;
         sync_q     <= '0;
         stable_q   <= '0;
         rise_en_q  <= '1;
         fall_en_q  <= '1;
         mask_q     <= '0;
         edge_q     <= '0;
         readdata_q <= '0;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         meta_q     <= in_port;
         sync_q     <= meta_q;
         stable_q   <= stable_d;
         rise_en_q  <= rise_en_d;
         fall_en_q  <= fall_en_d;
         mask_q     <= mask_d;
         edge_q     <= edge_d;
         readdata_q <= readdata_d;
         for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   assign readdata = readdata_q;
   assign irq      = |(edge_q & mask_q);

endmodule
